// File: rtl/col_parity_calculator.sv
// Column-parity datapath: folds both pages into per-column parities one column per
// cycle, then writes the result page one row per cycle. Optional port via COL_PARITY_DEBUG_EN.
module col_parity_calculator #(
    parameter int DIM = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [DIM*DIM-1:0]   cur_page_i,
    input  logic [DIM*DIM-1:0]   prev_page_i,
    output logic                 busy_o,
    output logic [DIM*DIM-1:0]   out_page_o,
`ifdef COL_PARITY_DEBUG_EN
    output logic [2*DIM-1:0]     parity_out_o,
`endif
    output logic                 finish_o
);

    localparam int W  = DIM * DIM;
    localparam int CW = $clog2(DIM);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIM - 1);

    typedef enum logic [1:0] {
        IDLE,
        PARITY,
        APPLY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      curCopy_q, curCopy_d;
    logic [W-1:0]      prevCopy_q, prevCopy_d;
    logic [DIM-1:0]    cCur_q, cCur_d;
    logic [DIM-1:0]    cPrev_q, cPrev_d;
    logic [W-1:0]      outPage_q, outPage_d;

    logic              colCur;
    logic              colPrev;
    logic [DIM-1:0]    rowBits;

    // Parity of column cnt, and row cnt of the result, from the latched copies
    always_comb begin
        colCur  = 1'b0;
        colPrev = 1'b0;
        rowBits = '0;
        for (int y = 0; y < DIM; y++) begin
            colCur  = colCur  ^ curCopy_q[DIM*y + int'(cnt_q)];
            colPrev = colPrev ^ prevCopy_q[DIM*y + int'(cnt_q)];
        end
        for (int x = 0; x < DIM; x++) begin
            rowBits[x] = curCopy_q[DIM*int'(cnt_q) + x]
                       ^ cCur_q[(x + DIM - 1) % DIM]
                       ^ cPrev_q[(x + 1) % DIM];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        curCopy_d  = curCopy_q;
        prevCopy_d = prevCopy_q;
        cCur_d     = cCur_q;
        cPrev_d    = cPrev_q;
        outPage_d  = outPage_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    curCopy_d  = cur_page_i;
                    prevCopy_d = prev_page_i;
                    cnt_d      = '0;
                    state_d    = PARITY;
                end
            end
            PARITY: begin
                cCur_d[cnt_q]  = colCur;
                cPrev_d[cnt_q] = colPrev;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = APPLY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            APPLY: begin
                outPage_d[DIM*int'(cnt_q) +: DIM] = rowBits;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset aborts any operation; no finish follows an abort
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            curCopy_q  <= '0;
            prevCopy_q <= '0;
            cCur_q     <= '0;
            cPrev_q    <= '0;
            outPage_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            curCopy_q  <= curCopy_d;
            prevCopy_q <= prevCopy_d;
            cCur_q     <= cCur_d;
            cPrev_q    <= cPrev_d;
            outPage_q  <= outPage_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign finish_o   = (state_q == DONE);
    assign out_page_o = outPage_q;
`ifdef COL_PARITY_DEBUG_EN
    assign parity_out_o = {cPrev_q, cCur_q};
`endif

endmodule
